tdm_demux_nch: RTL and testbench

- Parametrised N-channel time-division demultiplexer for the ADC front end; successor of the 2-channel reference/contaminated splitter.
- Takes one multiplexed sample bus plus a level strobe from the LSCLK block (real sample clock), runs in the fast system clock domain.
- Rebuilds full frames and presents all N_CH channels time-aligned on one packed output bus, with a frame-valid pulse and a frame-rate clock for downstream LMS/filter blocks.

---
 rtl/tdm_demux_nch.sv | 98 +++++++++
 tb/tb_tdm_demux_nch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tdm_demux_nch.sv
// N-channel TDM demultiplexer: rebuilds frames from a strobed sample bus into one aligned packed output.
// Optional frame-marker checking is enabled with the TDM_SYNC_EN macro.
module tdm_demux_nch #(
    parameter int NB_SAMPLE = 8,
    parameter int N_CH      = 2,
    localparam int NB_CH    = $clog2(N_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_enable,
    input  logic [NB_SAMPLE-1:0]      i_signals,
    input  logic                      i_sync,
    output logic [N_CH*NB_SAMPLE-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_frame_clk,
    output logic [NB_CH-1:0]          o_ch_idx,
    output logic                      o_sync_err
);

    localparam logic [NB_CH-1:0] LAST_CH = NB_CH'(N_CH - 1);
    localparam logic [NB_CH-1:0] HALF_CH = NB_CH'(N_CH / 2);

    logic                            en_d;
    logic                            strb;
    logic [NB_CH-1:0]                ch_cnt;
    logic [NB_CH-1:0]                ch_nxt;
    logic [NB_CH-1:0]                wr_idx;
    logic                            wr_en;
    logic                            done;
    logic                            slip;
    logic                            err;
    logic [(N_CH-1)*NB_SAMPLE-1:0]   shadow;

    assign strb     = i_enable & ~en_d;
    assign o_ch_idx = ch_cnt;

`ifdef TDM_SYNC_EN
    always_comb begin
        slip = 1'b0;
        err  = 1'b0;
        if (strb) begin
            slip = i_sync && (ch_cnt != '0);
            err  = (i_sync && (ch_cnt != '0)) || (!i_sync && (ch_cnt == '0));
        end
    end
`else
    logic unused_sync;
    assign unused_sync = i_sync;
    assign slip        = 1'b0;
    assign err         = 1'b0;
`endif

    // A slip restarts the frame with this sample as channel 0, ahead of frame completion.
    always_comb begin
        ch_nxt = ch_cnt;
        wr_en  = 1'b0;
        wr_idx = ch_cnt;
        done   = 1'b0;
        if (strb) begin
            if (slip) begin
                wr_en  = 1'b1;
                wr_idx = '0;
                ch_nxt = NB_CH'(1);
            end else if (ch_cnt == LAST_CH) begin
                done   = 1'b1;
                ch_nxt = '0;
            end else begin
                wr_en  = 1'b1;
                ch_nxt = ch_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_d        <= 1'b1;
            ch_cnt      <= '0;
            shadow      <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_clk <= 1'b1;
            o_sync_err  <= 1'b0;
        end else begin
            en_d   <= i_enable;
            ch_cnt <= ch_nxt;
            for (int unsigned i = 0; i < N_CH - 1; i++) begin
                if (wr_en && (wr_idx == NB_CH'(i)))
                    shadow[i*NB_SAMPLE +: NB_SAMPLE] <= i_signals;
            end
            if (done)
                o_data <= {i_signals, shadow};
            o_valid     <= done;
            o_frame_clk <= (ch_nxt < HALF_CH);
            o_sync_err  <= err;
        end
    end

endmodule

// File: tb/tb_tdm_demux_nch.sv
// Scoreboard bench for tdm_demux_nch (N_CH=4): driver feeds a sample-list model, monitor checks outputs.
module tb_tdm_demux_nch;

    localparam int NB_SAMPLE = 8;
    localparam int N_CH      = 4;
    localparam int NB_CH     = $clog2(N_CH);
    localparam int W         = N_CH * NB_SAMPLE;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 i_enable = 1'b1;
    logic [NB_SAMPLE-1:0] i_signals = '0;
    logic                 i_sync = 1'b0;
    logic [W-1:0]         o_data;
    logic                 o_valid;
    logic                 o_frame_clk;
    logic [NB_CH-1:0]     o_ch_idx;
    logic                 o_sync_err;

    tdm_demux_nch #(.NB_SAMPLE(NB_SAMPLE), .N_CH(N_CH)) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_signals(i_signals),
        .i_sync(i_sync), .o_data(o_data), .o_valid(o_valid),
        .o_frame_clk(o_frame_clk), .o_ch_idx(o_ch_idx), .o_sync_err(o_sync_err)
    );

    always #5 clk = ~clk;

    int unsigned          n_checks = 0;
    int unsigned          n_pass   = 0;
    int unsigned          n_valid  = 0;
    int unsigned          n_frames = 0;
    logic [NB_SAMPLE-1:0] part[$];
    logic [W-1:0]         exp_q[$];
    logic [W-1:0]         last_frame = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: samples accumulate in arrival order; every N_CH of them form one frame.
    task automatic model_capture(input logic [NB_SAMPLE-1:0] s);
        logic [W-1:0] f;
        part.push_back(s);
        if (part.size() == N_CH) begin
            f = '0;
            for (int k = 0; k < N_CH; k++) f[k*NB_SAMPLE +: NB_SAMPLE] = part[k];
            exp_q.push_back(f);
            n_frames++;
            part.delete();
        end
    endtask

    task automatic strobe(input logic [NB_SAMPLE-1:0] s, input int hold, input int low);
        i_enable = 1'b0;
        repeat (low) @(posedge clk);
        #1;
        i_signals = s;
        i_enable  = 1'b1;
        @(posedge clk);
        #1;
        model_capture(s);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            i_signals = NB_SAMPLE'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        part.delete();
        last_frame = '0;
        @(posedge clk);
        #1;
        chk("rst_o_data", o_data, '0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ch_idx", o_ch_idx, 0);
        chk("rst_o_frame_clk", o_frame_clk, 1);
        chk("rst_o_sync_err", o_sync_err, 0);
        rst = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_valid) begin
                    n_valid++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", o_valid, 0);
                    end else begin
                        last_frame = exp_q.pop_front();
                        chk("frame_data", o_data, last_frame);
                    end
                end else begin
                    chk("hold_data", o_data, last_frame);
                end
                chk("ch_idx", o_ch_idx, part.size());
                chk("frame_clk", o_frame_clk, (part.size() < N_CH / 2));
                chk("sync_err", o_sync_err, 0);
            end
        end
    end

    initial begin : driver
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        for (int k = 1; k <= 8; k++) strobe(NB_SAMPLE'(k), 0, 2);
        for (int k = 0; k < N_CH; k++) strobe(NB_SAMPLE'($urandom), 500, 1);
        strobe(8'h80, 1, 1);
        strobe(8'h7F, 1, 1);
        strobe(8'h00, 1, 1);
        strobe(8'hFF, 1, 1);
        strobe(8'hC3, 2, 1);
        strobe(8'h3C, 2, 1);
        do_reset();
        for (int k = 1; k <= 4; k++) strobe(NB_SAMPLE'(8'hA0 + k), 1, 3);
        for (int k = 0; k < 40; k++)
            strobe(NB_SAMPLE'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(1, 4)));
        i_enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("valid_count", n_valid, n_frames);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
